pcm_tdm_scheduler: RTL and testbench

Time-division scheduler that shares one 8-bit PCM companding encoder between `NCH` sample sources. Frame order:
- one sync word;
- then one slot per channel in fixed order 0..NCH-1.

For each slot the block feeds that channel's sample to the encoder's `datain`, waits out the encoder's one-cycle register stage, captures the 8-bit code from `PCMout`, and presents it downstream on a valid/ready stream tagged with channel number and sync flag. It sits between the channel sample buffers and the Hamming/FSK transmit chain.

---
 rtl/pcm_pkg.sv | 18 +
 rtl/pcm_tdm_scheduler.sv | 160 ++++++++++++++++
 tb/tb_pcm_tdm_scheduler.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pcm_pkg.sv
// rtl/pcm_pkg.sv - shared types and constants for the PCM TDM scheduler
package pcm_pkg;

  localparam int PCM_W = 8;

  localparam logic [PCM_W-1:0] SYNC_WORD_DEF   = 8'h9B;
  localparam logic [PCM_W-1:0] IDLE_SAMPLE_DEF = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_LOAD,
    ST_ENC,
    ST_CAP,
    ST_OUT
  } pcm_sched_state_t;

endpackage

// File: rtl/pcm_tdm_scheduler.sv
// rtl/pcm_tdm_scheduler.sv - shares one registered PCM encoder across NCH channels in sync-led frames
module pcm_tdm_scheduler
  import pcm_pkg::*;
#(
  parameter int               NCH         = 4,
  parameter logic [PCM_W-1:0] SYNC_WORD   = SYNC_WORD_DEF,
  parameter logic [PCM_W-1:0] IDLE_SAMPLE = IDLE_SAMPLE_DEF
) (
  input  logic                     clk_character_rate,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [NCH-1:0]           ch_valid,
  input  logic [PCM_W*NCH-1:0]     ch_data,
  output logic [NCH-1:0]           ch_ready,
  output logic [PCM_W-1:0]         enc_datain,
  input  logic [PCM_W-1:0]         enc_pcm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PCM_W-1:0]         out_data,
  output logic                     out_sync,
  output logic [$clog2(NCH)-1:0]   out_ch,
  output logic                     out_idle,
  output logic [7:0]               frame_cnt
);

  localparam int                SLOT_W    = $clog2(NCH);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NCH - 1);

  pcm_sched_state_t  state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [PCM_W-1:0]  enc_datain_q, enc_datain_d;
  logic [PCM_W-1:0]  out_q, out_d;
  logic              idle_q, idle_d;
  logic              out_valid_q, out_valid_d;
  logic              out_sync_q, out_sync_d;
  logic [SLOT_W-1:0] out_ch_q, out_ch_d;
  logic              out_idle_q, out_idle_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic [PCM_W-1:0]  slot_sample;

  assign slot_sample = ch_data[slot_q*PCM_W +: PCM_W];

  always_comb begin
    ch_ready = '0;
    if (state_q == ST_LOAD) ch_ready[slot_q] = ch_valid[slot_q];
  end

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    enc_datain_d = enc_datain_q;
    out_d        = out_q;
    idle_d       = idle_q;
    out_valid_d  = out_valid_q;
    out_sync_d   = out_sync_q;
    out_ch_d     = out_ch_q;
    out_idle_d   = out_idle_q;
    frame_cnt_d  = frame_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d     = ST_SYNC;
          out_valid_d = 1'b1;
          out_sync_d  = 1'b1;
          out_d       = SYNC_WORD;
          out_ch_d    = '0;
          out_idle_d  = 1'b0;
        end
      end
      ST_SYNC: begin
        if (out_ready) begin
          state_d     = ST_LOAD;
          slot_d      = '0;
          out_valid_d = 1'b0;
          out_sync_d  = 1'b0;
        end
      end
      ST_LOAD: begin
        state_d = ST_ENC;
        if (ch_valid[slot_q]) begin
          enc_datain_d = slot_sample;
          idle_d       = 1'b0;
        end else begin
          enc_datain_d = IDLE_SAMPLE;
          idle_d       = 1'b1;
        end
      end
      ST_ENC: state_d = ST_CAP;
      // encoder output reflects enc_datain only now, one cycle after it was registered
      ST_CAP: begin
        state_d     = ST_OUT;
        out_d       = enc_pcm;
        out_ch_d    = slot_q;
        out_idle_d  = idle_q;
        out_valid_d = 1'b1;
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (slot_q != LAST_SLOT) begin
            slot_d  = slot_q + SLOT_W'(1);
            state_d = ST_LOAD;
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
            if (enable) begin
              state_d     = ST_SYNC;
              out_valid_d = 1'b1;
              out_sync_d  = 1'b1;
              out_d       = SYNC_WORD;
              out_ch_d    = '0;
              out_idle_d  = 1'b0;
            end else begin
              state_d    = ST_IDLE;
              out_sync_d = 1'b0;
              out_d      = '0;
              out_ch_d   = '0;
              out_idle_d = 1'b0;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_character_rate or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      slot_q       <= '0;
      enc_datain_q <= '0;
      out_q        <= '0;
      idle_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_sync_q   <= 1'b0;
      out_ch_q     <= '0;
      out_idle_q   <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      enc_datain_q <= enc_datain_d;
      out_q        <= out_d;
      idle_q       <= idle_d;
      out_valid_q  <= out_valid_d;
      out_sync_q   <= out_sync_d;
      out_ch_q     <= out_ch_d;
      out_idle_q   <= out_idle_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign enc_datain = enc_datain_q;
  assign out_data   = out_q;
  assign out_valid  = out_valid_q;
  assign out_sync   = out_sync_q;
  assign out_ch     = out_ch_q;
  assign out_idle   = out_idle_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_pcm_tdm_scheduler.sv
// tb/tb_pcm_tdm_scheduler.sv - bench for pcm_tdm_scheduler with a registered segment-encoder model
module tb_pcm_tdm_scheduler;

  localparam int NCH = 4;

  logic        clk_character_rate;
  logic        reset;
  logic        enable;
  logic [3:0]  ch_valid;
  logic [31:0] ch_data;
  logic [3:0]  ch_ready;
  logic [7:0]  enc_datain;
  logic [7:0]  enc_pcm;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_sync;
  logic [1:0]  out_ch;
  logic        out_idle;
  logic [7:0]  frame_cnt;

  typedef struct {
    logic [11:0] w;
    int          cyc;
  } word_t;

  word_t got[$];
  int    cons[NCH];
  int    checks;
  int    errors;
  int    cyc;
  int    exp_frames;

  pcm_tdm_scheduler dut (
    .clk_character_rate(clk_character_rate),
    .reset(reset),
    .enable(enable),
    .ch_valid(ch_valid),
    .ch_data(ch_data),
    .ch_ready(ch_ready),
    .enc_datain(enc_datain),
    .enc_pcm(enc_pcm),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_sync(out_sync),
    .out_ch(out_ch),
    .out_idle(out_idle),
    .frame_cnt(frame_cnt)
  );

  initial clk_character_rate = 1'b0;
  always #5 clk_character_rate = ~clk_character_rate;

  // Sign + 3-bit segment (msb position + 1) + 4 mantissa bits below the msb
  function automatic logic [7:0] enc_fn(input logic [7:0] x);
    logic [6:0]  m;
    logic [10:0] t;
    int          p;
    m = x[6:0];
    if (m == 7'd0) return {x[7], 7'd0};
    p = 6;
    while (!m[p]) p--;
    t = {m, 4'b0000} >> p;
    return {x[7], 3'(p + 1), t[3:0]};
  endfunction

  always_ff @(posedge clk_character_rate or posedge reset) begin
    if (reset) enc_pcm <= 8'h00;
    else       enc_pcm <= enc_fn(enc_datain);
  end

  function automatic logic [11:0] exp_word(input int k, input logic [3:0] mask, input logic [31:0] data);
    logic [7:0] s;
    int         i;
    if (k == 0) return {1'b1, 2'd0, 1'b0, 8'h9B};
    i = k - 1;
    s = mask[i] ? data[8*i +: 8] : 8'h00;
    return {1'b0, 2'(i), ~mask[i], enc_fn(s)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    word_t w;
    if (out_valid === 1'b1 && out_ready) begin
      w.w   = {out_sync, out_ch, out_idle, out_data};
      w.cyc = cyc;
      got.push_back(w);
    end
    for (int i = 0; i < NCH; i++) if (ch_ready[i]) cons[i]++;
    chk("ch_ready_onehot_subset", 32'($onehot0(ch_ready) && ((ch_ready & ~ch_valid) == 4'd0)), 32'd1);
    @(posedge clk_character_rate);
    #1;
    cyc++;
  endtask

  // mode: 0 ready always, 1 random ready, 2 five-cycle stall at slot 1, 3 drop enable at slot 1
  task automatic run_frame(input logic [3:0] mask, input logic [31:0] data, input int mode, input int exp_len);
    int         guard;
    int         stall;
    logic [7:0] h_data;
    logic [7:0] h_enc;
    logic [1:0] h_ch;
    ch_valid = mask;
    ch_data  = data;
    enable   = 1'b1;
    got.delete();
    for (int i = 0; i < NCH; i++) cons[i] = 0;
    stall  = 0;
    guard  = 0;
    h_data = 8'h00;
    h_enc  = 8'h00;
    h_ch   = 2'd0;
    while (got.size() < NCH + 1 && guard < 400) begin
      case (mode)
        1: out_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (out_valid && !out_sync && out_ch == 2'd1 && stall < 5) begin
            if (stall == 0) begin
              h_data = out_data;
              h_ch   = out_ch;
              h_enc  = enc_datain;
            end else begin
              chk("stall_out_data", out_data, h_data);
              chk("stall_out_ch", out_ch, h_ch);
              chk("stall_enc_datain", enc_datain, h_enc);
            end
            out_ready = 1'b0;
            stall++;
          end else begin
            out_ready = 1'b1;
          end
        end
        3: begin
          out_ready = 1'b1;
          if (out_valid && !out_sync && out_ch == 2'd1) enable = 1'b0;
        end
        default: out_ready = 1'b1;
      endcase
      tick();
      guard++;
    end
    chk("frame_word_count", got.size(), NCH + 1);
    for (int k = 0; k < got.size(); k++)
      chk($sformatf("frame_word%0d", k), got[k].w, exp_word(k, mask, data));
    for (int i = 0; i < NCH; i++)
      chk($sformatf("ch_ready_pulses%0d", i), cons[i], 32'(mask[i]));
    exp_frames++;
    chk("frame_cnt", frame_cnt, exp_frames & 255);
    if (mode == 2) chk("stall_cycles", stall, 5);
    if (exp_len > 0 && got.size() == NCH + 1)
      chk("frame_len", got[NCH].cyc - got[0].cyc + 1, exp_len);
  endtask

  initial begin
    int guard;
    checks     = 0;
    errors     = 0;
    cyc        = 0;
    exp_frames = 0;
    reset      = 1'b1;
    enable     = 1'b0;
    ch_valid   = 4'h0;
    ch_data    = 32'h0;
    out_ready  = 1'b0;
    repeat (3) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sync", out_sync, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_out_idle", out_idle, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_enc_datain", enc_datain, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_ch_ready", ch_ready, 0);
    reset = 1'b0;
    repeat (2) tick();
    chk("idle_out_valid", out_valid, 0);

    run_frame(4'hF, 32'h7F10_8001, 0, 17);
    run_frame(4'b1011, 32'h7F10_8001, 0, 17);
    run_frame(4'hF, 32'h7F10_8001, 2, 22);
    for (int f = 0; f < 20; f++)
      run_frame(4'($urandom_range(0, 15)), $urandom, 1, 0);

    run_frame(4'hF, $urandom, 3, 17);
    got.delete();
    repeat (12) begin
      chk("disabled_out_valid", out_valid, 0);
      tick();
    end
    chk("disabled_no_words", got.size(), 0);
    run_frame(4'($urandom_range(0, 15)), $urandom, 0, 17);

    ch_valid  = 4'hF;
    ch_data   = $urandom;
    out_ready = 1'b1;
    enable    = 1'b1;
    got.delete();
    guard = 0;
    while (got.size() < 3 && guard < 100) begin
      tick();
      guard++;
    end
    chk("pre_reset_words", got.size(), 3);
    tick();
    #2 reset = 1'b1;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_out_data", out_data, 0);
    chk("async_rst_out_ch", out_ch, 0);
    chk("async_rst_out_sync", out_sync, 0);
    chk("async_rst_out_idle", out_idle, 0);
    chk("async_rst_enc_datain", enc_datain, 0);
    chk("async_rst_ch_ready", ch_ready, 0);
    chk("async_rst_frame_cnt", frame_cnt, 0);
    #1 reset = 1'b0;
    got.delete();
    guard = 0;
    while (got.size() < 1 && guard < 100) begin
      tick();
      guard++;
    end
    chk("post_reset_words", got.size(), 1);
    if (got.size() > 0) chk("post_reset_sync", got[0].w, {1'b1, 2'd0, 1'b0, 8'h9B});

    enable = 1'b0;
    reset  = 1'b1;
    repeat (2) tick();
    reset      = 1'b0;
    exp_frames = 0;
    for (int f = 0; f < 256; f++)
      run_frame(4'($urandom_range(0, 15)), $urandom, 0, 17);
    chk("frame_cnt_wrap", frame_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
